rr_arbiter4: RTL
================

# rr_arbiter4

Four-requester round-robin arbiter with bounded grant tenure, for sharing one downstream resource such as a bus or memory port between four masters. It extends the two-requester fixed arbiter: the rotating priority pointer prevents starvation. A hold counter preempts a master that keeps its request asserted while others wait. Grants are registered and one-hot, with one idle turnaround cycle between owners.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive grant cycles while another requester is pending; legal range 1..256.
- `clk`  in  1: clock; all state updates on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  4: request per master; level-sensitive, held until done.
- `gnt`  out  4: one-hot grant, registered; at most one bit set.
- `gnt_vld`  out  1: equals OR of `gnt`.
- `gnt_id`  out  2: index of current owner; holds last owner when `gnt_vld`=0.
- `preempt`  out  1: one-cycle pulse, asserted the cycle after a grant is removed by tenure expiry.

## Operation
- Reset values: `gnt`=0000, `gnt_vld`=0, `gnt_id`=0, `preempt`=0, state IDLE, `ptr`=0, `hold_cnt`=0.
- States:
  - IDLE: no grant. If any `req` bit is set, register a grant to the winner, load `hold_cnt`=0 and go to GRANT. Otherwise stay in IDLE.
  - GRANT: `gnt[owner]`=1.
    - If `req[owner]`=0, clear the grant, set `ptr`=(owner+1) mod 4 and go to IDLE. This is a normal release.
    - Else, if `hold_cnt`==MAX_HOLD-1 and any other `req` bit is set, clear the grant, set `ptr`=(owner+1) mod 4, set `preempt`=1 next cycle and go to IDLE. This is preemption.
    - Else stay in GRANT. `hold_cnt` increments and saturates at MAX_HOLD-1.
- Winner selection: scan `req` starting at index `ptr`, then ptr+1, ptr+2, ptr+3, wrapping mod 4. The first set bit wins.
- Saturation: a sole requester keeps the grant indefinitely. If another request appears while the counter is saturated, preemption occurs at the next edge.
- `ptr` updates only on a grant release; it is unchanged while in IDLE with no requests.
- `hold_cnt` width is clog2(MAX_HOLD), minimum 1 bit.
- MAX_HOLD=1: an owner is preempted after every cycle when contention exists.
- Requests from non-owners during GRANT are ignored until the next IDLE cycle.
- `preempt` is 0 in every cycle except the single cycle following a preemptive release.
- `rst` dominates everything. Reset asserted during GRANT clears `gnt` at that edge. The following grant is decided with `ptr`=0.

## Timing
- Grant latency: `req` sampled high in IDLE at edge k gives `gnt` high from edge k.
- Release latency: `req[owner]` sampled low at edge k clears `gnt` from edge k. The earliest next grant is from edge k+1, so there is exactly one idle turnaround cycle.
- Tenure under contention: the grant is visible for exactly MAX_HOLD cycles, then one idle cycle, then the next owner.
- Full rotation under continuous all-request load: the period is 4·(MAX_HOLD+1) cycles.
- `gnt`, `gnt_vld`, `gnt_id` and `preempt` all change only on clock edges.
- No combinational path exists from `req` to any output.

## Test plan
1. Reset check: hold `rst`=1 for 2 cycles with `req`=1111.
   - All outputs must stay at reset values during reset.
   - The first edge after `rst`=0 gives `gnt`=0001 and `gnt_id`=0.
2. Single requester: `req`=0100 held for 10 cycles, then 0000.
   - `gnt`=0100 from the next edge, held for all 10 cycles with no preemption.
   - `gnt` drops on the edge that samples `req`=0; `ptr` becomes 3.
3. Full contention with MAX_HOLD=4: `req`=1111 held continuously.
   - Owners must go 0,1,2,3,0, each for 4 cycles, separated by 1 idle cycle.
   - `preempt` pulses once per handover.
4. Wrap-around: release owner 3 with `req`=1001 pending.
   - The next grant goes to 0, then owner 3 on 0's release.
   - No index may be skipped or repeated.
5. Saturation then contention: `req`=0010 for 8 cycles, then `req`=0011.
   - Master 1 keeps its grant for 8 cycles.
   - It is preempted at the first edge after `req[0]` rises: `gnt`=0000 with `preempt`=1.
   - The following cycle gives `gnt`=0001.
6. Reset mid-grant: assert `rst` for 1 cycle while `gnt`=1000 and `req`=1100.
   - `gnt` clears at that edge.
   - After reset, the grant goes to 2, because `ptr` resets to 0 and the scan reaches req[2] first.

Source files
------------

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between four masters and the round-robin arbiter.
interface rr_arbiter4_if;
   logic [3:0] req;
   logic [3:0] gnt;
   logic       gnt_vld;
   logic [1:0] gnt_id;
   logic       preempt;

   modport master (output req, input gnt, gnt_vld, gnt_id, preempt);
   modport slave  (input req, output gnt, gnt_vld, gnt_id, preempt);
endinterface

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with bounded tenure under contention.
// Registered one-hot grant, one idle turnaround cycle between owners.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no grant; pick winner scanning req from ptr upward
//   GRANT | gnt[gnt_id] held; release on drop or on tenure expiry
module rr_arbiter4 #(
   parameter int MAX_HOLD = 4
) (
   input logic         clk,
   input logic         rst,
   rr_arbiter4_if.slave bus
);

   localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HW-1:0] HOLD_TC = HW'(MAX_HOLD - 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t          state_q, state_d;
   logic [1:0]      ptr_q, ptr_d;
   logic [HW-1:0]   hold_cnt_q, hold_d;
   logic [3:0]      gnt_q, gnt_d;
   logic [1:0]      gnt_id_q, gnt_id_d;
   logic            preempt_q, preempt_d;

   logic [1:0]      cand;
   logic [1:0]      winner;
   logic            found;
   logic [3:0]      others;

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      hold_d    = hold_cnt_q;
      gnt_d     = gnt_q;
      gnt_id_d  = gnt_id_q;
      preempt_d = 1'b0;
      cand      = ptr_q;
      winner    = ptr_q;
      found     = 1'b0;
      others    = bus.req & ~gnt_q;

      for (int i = 0; i < 4; i++) begin
         cand = ptr_q + 2'(i);
         if (!found && bus.req[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end

      case (state_q)
         IDLE: begin
            if (found) begin
               gnt_d    = 4'b0001 << winner;
               gnt_id_d = winner;
               hold_d   = '0;
               state_d  = GRANT;
            end
         end
         GRANT: begin
            if (!bus.req[gnt_id_q]) begin
               gnt_d   = '0;
               ptr_d   = gnt_id_q + 2'd1;
               state_d = IDLE;
            end else if (hold_cnt_q == HOLD_TC && |others) begin
               gnt_d     = '0;
               ptr_d     = gnt_id_q + 2'd1;
               preempt_d = 1'b1;
               state_d   = IDLE;
            end else if (hold_cnt_q != HOLD_TC) begin
               hold_d = hold_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         hold_cnt_q <= '0;
         gnt_q      <= '0;
         gnt_id_q   <= '0;
         preempt_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         hold_cnt_q <= hold_d;
         gnt_q      <= gnt_d;
         gnt_id_q   <= gnt_id_d;
         preempt_q  <= preempt_d;
      end
   end

   // Outputs come straight from registers; no path from req.
   assign bus.gnt     = gnt_q;
   assign bus.gnt_vld = |gnt_q;
   assign bus.gnt_id  = gnt_id_q;
   assign bus.preempt = preempt_q;

endmodule
